// File: rtl/branch_resolve_unit_pkg.sv
// Shared opcode/funct3 constants and FSM state type for the branch resolve unit.
package branch_resolve_unit_pkg;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_EX,
      REDIRECT,
      DRAIN
   } bru_state_t;

   // True for opcodes that change control flow (LUI/AUIPC excluded)
   function automatic logic is_control(input logic [6:0] op);
      return (op == OP_JAL) || (op == OP_JALR) || (op == OP_BRANCH);
   endfunction

endpackage

// File: rtl/branch_resolve_unit_compare.sv
// Branch condition evaluation: the single home of signed/unsigned compare rules.
module branch_compare
   import branch_resolve_unit_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            cond_true
);

   // Select the comparison named by funct3; reserved encodings never take
   always_comb begin
      cond_true = 1'b0;
      case (funct3)
         F3_BEQ:  cond_true = (rs1 == rs2);
         F3_BNE:  cond_true = (rs1 != rs2);
         F3_BLT:  cond_true = ($signed(rs1) <  $signed(rs2));
         F3_BGE:  cond_true = ($signed(rs1) >= $signed(rs2));
         F3_BLTU: cond_true = (rs1 <  rs2);
         F3_BGEU: cond_true = (rs1 >= rs2);
         default: cond_true = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolution: stalls fetch on a decoded control
// instruction, resolves it in execute, redirects/flushes when taken, drains.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned DRAIN_CYCLES   = 2,
   parameter int unsigned TIMEOUT_CYCLES = 8
) (
   input  logic            clk,
   input  logic            res,
   input  logic            id_valid,
   input  logic [6:0]      id_opcode,
   input  logic            ex_valid,
   input  logic [6:0]      ex_opcode,
   input  logic [2:0]      ex_funct3,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_imm,
   input  logic [XLEN-1:0] ex_rs1,
   input  logic [XLEN-1:0] ex_rs2,
   output logic            stall,
   output logic            flush,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            taken,
   output logic            timeout_err
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0] DRN_LAST = 4'(DRAIN_CYCLES - 1);

   bru_state_t      state_q, state_d;
   logic [7:0]      tmo_q, tmo_d;
   logic [3:0]      drn_q, drn_d;

   logic            stall_d, flush_d, rv_d, taken_d, terr_d;
   logic [XLEN-1:0] rpc_d;

   logic            cond_true;
   logic            ex_fire;
   logic            id_fire;
   logic            res_taken;
   logic [XLEN-1:0] target;

   branch_compare #(.XLEN(XLEN)) u_cmp (
      .funct3    (ex_funct3),
      .rs1       (ex_rs1),
      .rs2       (ex_rs2),
      .cond_true (cond_true)
   );

   assign id_fire = id_valid && is_control(id_opcode);
   assign ex_fire = ex_valid && is_control(ex_opcode);

   // Resolve outcome and target from the execute slot
   always_comb begin
      res_taken = 1'b0;
      target    = ex_pc + ex_imm;
      if (ex_opcode == OP_JAL) begin
         res_taken = 1'b1;
      end else if (ex_opcode == OP_JALR) begin
         res_taken = 1'b1;
         target    = (ex_rs1 + ex_imm) & ~XLEN'(1);
      end else if (ex_opcode == OP_BRANCH) begin
         res_taken = cond_true;
      end
   end

   // State, counters and all outputs registered; reset aborts with no redirect
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state_q        <= IDLE;
         tmo_q          <= '0;
         drn_q          <= '0;
         stall          <= 1'b0;
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         taken          <= 1'b0;
         timeout_err    <= 1'b0;
      end else begin
         state_q        <= state_d;
         tmo_q          <= tmo_d;
         drn_q          <= drn_d;
         stall          <= stall_d;
         flush          <= flush_d;
         redirect_valid <= rv_d;
         redirect_pc    <= rpc_d;
         taken          <= taken_d;
         timeout_err    <= terr_d;
      end
   end

   // Next-state selection
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (id_fire) state_d = WAIT_EX;
         WAIT_EX: begin
            if (ex_fire)               state_d = REDIRECT;
            else if (tmo_q == TMO_LAST) state_d = IDLE;
         end
         REDIRECT: state_d = DRAIN;
         DRAIN:    if (drn_q == DRN_LAST) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Next values for registered outputs and counters
   always_comb begin
      stall_d = (state_d != IDLE);
      flush_d = 1'b0;
      rv_d    = 1'b0;
      rpc_d   = redirect_pc;
      taken_d = taken;
      terr_d  = 1'b0;
      tmo_d   = tmo_q;
      drn_d   = drn_q;
      case (state_q)
         IDLE: begin
            tmo_d = '0;
            drn_d = '0;
         end
         WAIT_EX: begin
            if (ex_fire) begin
               taken_d = res_taken;
               rv_d    = res_taken;
               flush_d = res_taken;
               if (res_taken) rpc_d = target;
            end else if (tmo_q == TMO_LAST) begin
               terr_d = 1'b1;
               tmo_d  = '0;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         REDIRECT: drn_d = '0;
         DRAIN:    drn_d = drn_q + 4'd1;
         default:  ;
      endcase
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed plan plus random transactions.
module tb_branch_resolve_unit;

   localparam int unsigned D = 2;
   localparam int unsigned T = 8;

   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;

   logic        clk = 1'b0;
   logic        res;
   logic        id_valid;
   logic [6:0]  id_opcode;
   logic        ex_valid;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_pc, ex_imm, ex_rs1, ex_rs2;
   logic        stall, flush, redirect_valid, taken, timeout_err;
   logic [31:0] redirect_pc;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;
   logic        last_taken = 1'b0;

   branch_resolve_unit #(
      .XLEN(32), .DRAIN_CYCLES(D), .TIMEOUT_CYCLES(T)
   ) dut (
      .clk(clk), .res(res),
      .id_valid(id_valid), .id_opcode(id_opcode),
      .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
      .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .taken(taken), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk1(input string tag, input logic obs, input logic want);
      n_assert++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, want);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_assert++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
   endtask

   function automatic longint to_signed(input logic [31:0] v);
      longint s;
      s = longint'(v);
      if (v[31]) s = s - 64'sd4294967296;
      return s;
   endfunction

   // Outcome from the ISA rules, using 64-bit integer arithmetic
   function automatic logic ref_taken(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [31:0] a, input logic [31:0] b);
      longint ua, ub, sa, sb;
      if (op == JAL || op == JALR) return 1'b1;
      if (op != BRANCH) return 1'b0;
      ua = longint'(a); ub = longint'(b);
      sa = to_signed(a); sb = to_signed(b);
      case (f3)
         3'd0: return ua == ub;
         3'd1: return ua != ub;
         3'd4: return sa < sb;
         3'd5: return sa >= sb;
         3'd6: return ua < ub;
         3'd7: return ua >= ub;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] ref_target(input logic [6:0] op, input logic [31:0] pc,
                                              input logic [31:0] imm, input logic [31:0] a);
      longint s;
      if (op == JALR) begin
         s = (longint'(a) + longint'(imm)) % 64'sd4294967296;
         s = s - (s % 2);
      end else begin
         s = (longint'(pc) + longint'(imm)) % 64'sd4294967296;
      end
      return s[31:0];
   endfunction

   task automatic idle_inputs();
      id_valid = 1'b0; id_opcode = '0;
      ex_valid = 1'b0; ex_opcode = '0; ex_funct3 = '0;
      ex_pc = '0; ex_imm = '0; ex_rs1 = '0; ex_rs2 = '0;
   endtask

   // Execute-slot noise that must not resolve: invalid or non-control opcode
   task automatic ex_noise();
      ex_valid  = 1'($urandom_range(0, 1));
      ex_opcode = ($urandom_range(0, 1) != 0) ? LUI : AUIPC;
      ex_funct3 = 3'($urandom);
      ex_pc = $urandom; ex_imm = $urandom; ex_rs1 = $urandom; ex_rs2 = $urandom;
   endtask

   // One full detect -> resolve -> redirect -> drain transaction with timing checks
   task automatic run_ctrl(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic [31:0] pc, input logic [31:0] imm,
                           input logic [31:0] a, input logic [31:0] b,
                           input int unsigned gap);
      logic        et;
      logic [31:0] tgt;
      et  = ref_taken(op, f3, a, b);
      tgt = ref_target(op, pc, imm, a);
      id_valid = 1'b1; id_opcode = op;
      step();
      chk1({tag, ".stall_on"}, stall, 1'b1);
      chk1({tag, ".no_rv_wait"}, redirect_valid, 1'b0);
      for (int unsigned i = 0; i < gap; i++) begin
         id_opcode = BRANCH;
         ex_noise();
         step();
         chk1({tag, ".stall_wait"}, stall, 1'b1);
         chk1({tag, ".no_rv_noise"}, redirect_valid, 1'b0);
      end
      ex_valid = 1'b1; ex_opcode = op; ex_funct3 = f3;
      ex_pc = pc; ex_imm = imm; ex_rs1 = a; ex_rs2 = b;
      step();
      chk1({tag, ".taken"}, taken, et);
      chk1({tag, ".rv"}, redirect_valid, et);
      chk1({tag, ".flush"}, flush, et);
      chk1({tag, ".stall_redir"}, stall, 1'b1);
      if (et) chk32({tag, ".rpc"}, redirect_pc, tgt);
      ex_valid = 1'b0;
      step();
      chk1({tag, ".rv_off"}, redirect_valid, 1'b0);
      chk1({tag, ".flush_off"}, flush, 1'b0);
      chk1({tag, ".stall_drain"}, stall, 1'b1);
      for (int unsigned i = 1; i < D; i++) begin
         step();
         chk1({tag, ".stall_drain_n"}, stall, 1'b1);
      end
      id_valid = 1'b0;
      step();
      chk1({tag, ".stall_off"}, stall, 1'b0);
      chk1({tag, ".taken_hold"}, taken, et);
      last_taken = et;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0]  op;
      logic [31:0] a, b;

      res = 1'b1;
      idle_inputs();
      step();
      step();
      chk1("reset.stall", stall, 1'b0);
      chk1("reset.flush", flush, 1'b0);
      chk1("reset.rv", redirect_valid, 1'b0);
      chk32("reset.rpc", redirect_pc, 32'h0);
      chk1("reset.taken", taken, 1'b0);
      chk1("reset.terr", timeout_err, 1'b0);
      res = 1'b0;
      step();

      // LUI in decode must not stall
      id_valid = 1'b1; id_opcode = LUI;
      step();
      chk1("lui.no_stall", stall, 1'b0);
      id_valid = 1'b0;

      run_ctrl("beq", BRANCH, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 0);
      chk32("beq.rpc_literal", redirect_pc, 32'h120);
      run_ctrl("blt", BRANCH, 3'b100, 32'h200, 32'h40, 32'h1, 32'hFFFF_FFFF, 1);
      run_ctrl("bltu", BRANCH, 3'b110, 32'h300, 32'h40, 32'h1, 32'hFFFF_FFFF, 2);
      run_ctrl("jalr", JALR, 3'b000, 32'h400, 32'h13, 32'hFFFF_FFF0, 32'h0, 0);
      chk32("jalr.rpc_literal", redirect_pc, 32'h2);

      // Timeout: JAL detected, nothing resolves for T cycles
      id_valid = 1'b1; id_opcode = JAL;
      step();
      id_valid = 1'b0;
      chk1("tmo.stall_on", stall, 1'b1);
      for (int unsigned i = 1; i < T; i++) begin
         ex_noise();
         step();
         chk1("tmo.stall_wait", stall, 1'b1);
         chk1("tmo.no_err_early", timeout_err, 1'b0);
         chk1("tmo.no_rv", redirect_valid, 1'b0);
      end
      ex_noise();
      step();
      chk1("tmo.err", timeout_err, 1'b1);
      chk1("tmo.stall_off", stall, 1'b0);
      chk1("tmo.no_rv_end", redirect_valid, 1'b0);
      chk1("tmo.taken_kept", taken, last_taken);
      idle_inputs();
      step();
      chk1("tmo.err_pulse", timeout_err, 1'b0);

      // Reset one cycle into DRAIN
      id_valid = 1'b1; id_opcode = JAL;
      step();
      id_valid = 1'b0;
      ex_valid = 1'b1; ex_opcode = JAL; ex_pc = 32'h500; ex_imm = 32'h10;
      step();
      chk1("rst.taken_before", taken, 1'b1);
      ex_valid = 1'b0;
      step();
      step();
      chk1("rst.stall_before", stall, 1'b1);
      #2 res = 1'b1;
      #1;
      chk1("rst.stall", stall, 1'b0);
      chk1("rst.flush", flush, 1'b0);
      chk1("rst.rv", redirect_valid, 1'b0);
      chk1("rst.taken", taken, 1'b0);
      @(negedge clk);
      res = 1'b0;
      last_taken = 1'b0;
      step();
      chk1("rst.idle", stall, 1'b0);
      run_ctrl("post_rst_jal", JAL, 3'b000, 32'h600, 32'hFFFF_FF00, 32'h0, 32'h0, 0);

      // Random transactions against the reference model
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0:       op = JAL;
            1:       op = JALR;
            default: op = BRANCH;
         endcase
         a = $urandom;
         b = ($urandom_range(0, 2) == 0) ? a : $urandom;
         run_ctrl($sformatf("rnd%0d", n), op, 3'($urandom), $urandom, $urandom, a, b,
                  $urandom_range(0, T - 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
